id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
// - ID/EX pipeline register for the 5-stage MIPS core. Sits directly upstream of the ALU.
// - Registers decoded operands, immediate and control signals, and resolves RAW hazards by
//   forwarding from EX/MEM and MEM/WB.
// - Drives the ALU opCode/A/B inputs and detects load-use hazards, inserting a bubble when one occurs.
// PARAMETERS
// - DATA_W   32  datapath width (A, B, results)
// - REG_W    5   register-specifier width
// - OP_W     4   ALU opCode width
// PORTS
// - clk             in   1       rising-edge clock
// - reset           in   1       synchronous, active-high reset
// - stall           in   1       pipeline freeze (memory wait); hold all ID/EX state
// - flush           in   1       branch/jump squash; load a bubble
// - id_valid        in   1       ID stage holds a real instruction
// - id_rs/id_rt/id_rd     in  REG_W   decoded register specifiers
// - id_rs_data/id_rt_data in  DATA_W  register-file read data
// - id_imm          in   16      raw immediate field
// - id_signExt      in   1       1: sign-extend imm, 0: zero-extend
// - id_aluSrc       in   1       1: B = extended imm, 0: B = forwarded rt
// - id_regDst       in   1       1: dest = rd, 0: dest = rt
// - id_aluOp        in   OP_W    ALU opCode from ALU control
// - id_regWrite/id_memRead/id_memWrite/id_memToReg in 1   control bits
// - exmem_regWrite  in   1       EX/MEM writes a register
// - exmem_rd        in   REG_W   EX/MEM destination
// - exmem_result    in   DATA_W  EX/MEM ALU result
// - memwb_regWrite  in   1       MEM/WB writes a register
// - memwb_rd        in   REG_W   MEM/WB destination
// - memwb_result    in   DATA_W  MEM/WB writeback value
// - opCode          out  OP_W    to ALU
// - A, B            out  DATA_W  to ALU (forwarded)
// - ex_storeData    out  DATA_W  forwarded rt value for SW
// - ex_destReg      out  REG_W   selected destination register
// - ex_regWrite/ex_memRead/ex_memWrite/ex_memToReg out 1   registered control bits
// - ex_valid        out  1       EX holds a real instruction
// - load_use_hazard out  1       combinational; upstream must hold PC and IF/ID
// BEHAVIOUR
// - Latency: ID inputs are captured on a rising clk edge and drive opCode/A/B in the following cycle.
// - Reset: all registered state clears to zero. Resulting outputs:
//   opCode=4'b0000, ex_destReg=0, all ex_* control=0, ex_valid=0.
//   A, B and ex_storeData then follow the forwarding equations on zeroed operands.
// - Update priority per edge: reset > flush > stall > load_use_hazard > load.
//   - flush: load a bubble.
//   - stall: hold every register, including when load_use_hazard=1.
//   - hazard (no stall): load a bubble.
//   - load: capture ID inputs; ex_valid <= id_valid.
// - Bubble: ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg = 0;
//   opCode = 0; ex_destReg = 0.
// - ex_destReg is captured as id_regDst ? id_rd : id_rt.
//   Immediate extension happens at capture: {16{imm[15]&signExt}, imm}.
// - Forwarding is combinational from the registered rs/rt, applied per operand (rs, rt):
//   1. if exmem_regWrite && exmem_rd!=0 && exmem_rd==reg, use exmem_result (highest priority);
//   2. else if memwb_regWrite && memwb_rd!=0 && memwb_rd==reg, use memwb_result;
//   3. else use the registered read data.
//   Register $0 is never forwarded.
// - A = fwd(rs). B = aluSrc ? imm_ext : fwd(rt). ex_storeData = fwd(rt) regardless of aluSrc.
// - load_use_hazard = ex_valid && ex_memRead && ex_destReg!=0 && id_valid &&
//   (ex_destReg==id_rs || ex_destReg==id_rt).
// - Stall with a pending hazard: the hazard stays asserted; the bubble enters on the first
//   non-stalled edge.
// - Reset asserted mid-stall or mid-hazard: the state is cleared on that edge; no held value survives.
// STRUCTURE
// - mips_pkg:
//   - ALU opCode constants: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010,
//     ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_NOR=4'b1100.
//   - typedef enum fwd_sel_t {FWD_REG, FWD_EXMEM, FWD_MEMWB}.
//   - typedef struct id_ex_t holding the registered fields.
// - Sub-module forward_unit: combinational; inputs rs, rt and the EX/MEM and MEM/WB
//   write ports; outputs fwdA and fwdB of type fwd_sel_t. Instantiated once.
// TESTING
// - Reset then load id_aluOp=ALU_ADD, rs_data=1000, rt_data=200, aluSrc=0, no hazards
//   -> next cycle: opCode=4'b0010, A=1000, B=200, ex_valid=1.
// - Registered rs=8; exmem_rd=8, exmem_regWrite=1, result=55; memwb_rd=8, result=77
//   -> A=55 (EX/MEM wins). Drop exmem_regWrite -> A=77.
// - exmem_rd=0, exmem_regWrite=1, result=99; registered rs=0, rs_data=0 -> A=0 (no $0 forwarding).
// - EX holds LW to $9; ID issues ADD with rs=$9 -> load_use_hazard=1;
//   next edge ex_valid=0, ex_regWrite=0; the held ADD enters the following cycle.
// - aluSrc=1, signExt=1, imm=16'hFFFE -> B=32'hFFFF_FFFE;
//   the same with signExt=0 -> B=32'h0000_FFFE; ex_storeData = fwd(rt) in both cases.
// - Assert stall and flush together -> bubble loaded. Assert stall alone for 3 cycles ->
//   outputs unchanged. Assert reset during stall -> all registered fields zero on that edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS ID/EX stage: ALU opcodes, forwarding selects
// and the layout of the registered ID/EX fields.
package mips_pkg;

  localparam int MIPS_DATA_W = 32;
  localparam int MIPS_REG_W  = 5;
  localparam int MIPS_OP_W   = 4;

  localparam logic [MIPS_OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [MIPS_OP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [MIPS_OP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [MIPS_OP_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [MIPS_OP_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [MIPS_OP_W-1:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    FWD_REG,
    FWD_EXMEM,
    FWD_MEMWB
  } fwd_sel_t;

  typedef struct packed {
    logic                   valid;
    logic                   reg_write;
    logic                   mem_read;
    logic                   mem_write;
    logic                   mem_to_reg;
    logic [MIPS_OP_W-1:0]   alu_op;
    logic [MIPS_REG_W-1:0]  dest;
    logic [MIPS_REG_W-1:0]  rs;
    logic [MIPS_REG_W-1:0]  rt;
    logic [MIPS_DATA_W-1:0] rs_data;
    logic [MIPS_DATA_W-1:0] rt_data;
    logic [MIPS_DATA_W-1:0] imm_ext;
    logic                   alu_src;
  } id_ex_t;

  // Upper half replicates imm[15] only when sign extension is requested.
  function automatic logic [MIPS_DATA_W-1:0] ext_imm(input logic [15:0] imm,
                                                     input logic        sign_ext);
    return {{(MIPS_DATA_W-16){imm[15] & sign_ext}}, imm};
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational RAW forwarding select for the two EX operands; EX/MEM beats MEM/WB, $0 never forwards.
module forward_unit
  import mips_pkg::*;
#(
  parameter int REG_W = MIPS_REG_W
) (
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             exmem_regWrite,
  input  logic [REG_W-1:0] exmem_rd,
  input  logic             memwb_regWrite,
  input  logic [REG_W-1:0] memwb_rd,
  output fwd_sel_t         fwdA,
  output fwd_sel_t         fwdB
);

  logic w_exmem_live;
  logic w_memwb_live;

  assign w_exmem_live = exmem_regWrite && (exmem_rd != '0);
  assign w_memwb_live = memwb_regWrite && (memwb_rd != '0);

  always_comb begin
    fwdA = FWD_REG;
    fwdB = FWD_REG;
    if (w_exmem_live && exmem_rd == rs)      fwdA = FWD_EXMEM;
    else if (w_memwb_live && memwb_rd == rs) fwdA = FWD_MEMWB;
    if (w_exmem_live && exmem_rd == rt)      fwdB = FWD_EXMEM;
    else if (w_memwb_live && memwb_rd == rt) fwdB = FWD_MEMWB;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register: one-cycle capture, forwarded ALU operands, load-use bubble insertion.
// Stall freezes every field (bubbles included); flush or an unstalled load-use hazard loads a bubble.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = MIPS_DATA_W,
  parameter int REG_W  = MIPS_REG_W,
  parameter int OP_W   = MIPS_OP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [15:0]       id_imm,
  input  logic              id_signExt,
  input  logic              id_aluSrc,
  input  logic              id_regDst,
  input  logic [OP_W-1:0]   id_aluOp,
  input  logic              id_regWrite,
  input  logic              id_memRead,
  input  logic              id_memWrite,
  input  logic              id_memToReg,
  input  logic              exmem_regWrite,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regWrite,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [OP_W-1:0]   opCode,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] ex_storeData,
  output logic [REG_W-1:0]  ex_destReg,
  output logic              ex_regWrite,
  output logic              ex_memRead,
  output logic              ex_memWrite,
  output logic              ex_memToReg,
  output logic              ex_valid,
  output logic              load_use_hazard
);

  id_ex_t      r_ex;
  id_ex_t      w_load;
  fwd_sel_t    w_fwd_a;
  fwd_sel_t    w_fwd_b;
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;

  always_comb begin
    w_load            = '0;
    w_load.valid      = id_valid;
    w_load.reg_write  = id_regWrite;
    w_load.mem_read   = id_memRead;
    w_load.mem_write  = id_memWrite;
    w_load.mem_to_reg = id_memToReg;
    w_load.alu_op     = id_aluOp;
    w_load.dest       = id_regDst ? id_rd : id_rt;
    w_load.rs         = id_rs;
    w_load.rt         = id_rt;
    w_load.rs_data    = id_rs_data;
    w_load.rt_data    = id_rt_data;
    w_load.imm_ext    = ext_imm(id_imm, id_signExt);
    w_load.alu_src    = id_aluSrc;
  end

  // A load in EX whose destination feeds the instruction waiting in ID.
  assign load_use_hazard = r_ex.valid && r_ex.mem_read && (r_ex.dest != '0) && id_valid &&
                           ((r_ex.dest == id_rs) || (r_ex.dest == id_rt));

  // An all-zero record is the bubble: invalid, no side effects, opCode and dest cleared.
  always_ff @(posedge clk) begin
    if (reset)                r_ex <= '0;
    else if (flush)           r_ex <= '0;
    else if (!stall)          r_ex <= load_use_hazard ? '0 : w_load;
  end

  forward_unit #(.REG_W(REG_W)) u_forward_unit (
    .rs             (r_ex.rs),
    .rt             (r_ex.rt),
    .exmem_regWrite (exmem_regWrite),
    .exmem_rd       (exmem_rd),
    .memwb_regWrite (memwb_regWrite),
    .memwb_rd       (memwb_rd),
    .fwdA           (w_fwd_a),
    .fwdB           (w_fwd_b)
  );

  always_comb begin
    case (w_fwd_a)
      FWD_EXMEM: w_fwd_rs = exmem_result;
      FWD_MEMWB: w_fwd_rs = memwb_result;
      default:   w_fwd_rs = r_ex.rs_data;
    endcase
    case (w_fwd_b)
      FWD_EXMEM: w_fwd_rt = exmem_result;
      FWD_MEMWB: w_fwd_rt = memwb_result;
      default:   w_fwd_rt = r_ex.rt_data;
    endcase
  end

  assign opCode       = r_ex.alu_op;
  assign A            = w_fwd_rs;
  assign B            = r_ex.alu_src ? r_ex.imm_ext : w_fwd_rt;
  assign ex_storeData = w_fwd_rt;
  assign ex_destReg   = r_ex.dest;
  assign ex_regWrite  = r_ex.reg_write;
  assign ex_memRead   = r_ex.mem_read;
  assign ex_memWrite  = r_ex.mem_write;
  assign ex_memToReg  = r_ex.mem_to_reg;
  assign ex_valid     = r_ex.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a per-cycle model of the ID/EX stage plus literal spot checks.
module tb_id_ex_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic        id_signExt, id_aluSrc, id_regDst;
  logic [3:0]  id_aluOp;
  logic        id_regWrite, id_memRead, id_memWrite, id_memToReg;
  logic        exmem_regWrite, memwb_regWrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [3:0]  opCode;
  logic [31:0] A, B, ex_storeData;
  logic [4:0]  ex_destReg;
  logic        ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_valid, load_use_hazard;

  int total = 0;
  int bad   = 0;
  bit started = 0;

  // Model of what sits in EX; m_known is cleared by bubbles, whose operands are unspecified.
  logic        m_valid, m_rw, m_mr, m_mw, m_m2r, m_alusrc, m_known;
  logic [3:0]  m_op;
  logic [4:0]  m_dest, m_rs, m_rt;
  logic [31:0] m_rsd, m_rtd, m_imm;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_signExt(id_signExt), .id_aluSrc(id_aluSrc), .id_regDst(id_regDst),
    .id_aluOp(id_aluOp), .id_regWrite(id_regWrite), .id_memRead(id_memRead),
    .id_memWrite(id_memWrite), .id_memToReg(id_memToReg),
    .exmem_regWrite(exmem_regWrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regWrite(memwb_regWrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .opCode(opCode), .A(A), .B(B), .ex_storeData(ex_storeData), .ex_destReg(ex_destReg),
    .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_memToReg(ex_memToReg), .ex_valid(ex_valid), .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] regval);
    if (exmem_regWrite && exmem_rd != 0 && exmem_rd == r) return exmem_result;
    if (memwb_regWrite && memwb_rd != 0 && memwb_rd == r) return memwb_result;
    return regval;
  endfunction

  function automatic logic exp_hazard();
    return m_valid && m_mr && m_dest != 0 && id_valid && (m_dest == id_rs || m_dest == id_rt);
  endfunction

  always @(negedge clk) begin
    if (started) begin
      chk("opCode", opCode, m_op);
      chk("ex_valid", ex_valid, m_valid);
      chk("ex_destReg", ex_destReg, m_dest);
      chk("ex_regWrite", ex_regWrite, m_rw);
      chk("ex_memRead", ex_memRead, m_mr);
      chk("ex_memWrite", ex_memWrite, m_mw);
      chk("ex_memToReg", ex_memToReg, m_m2r);
      chk("load_use_hazard", load_use_hazard, exp_hazard());
      if (m_known) begin
        chk("A", A, fwd(m_rs, m_rsd));
        chk("B", B, m_alusrc ? m_imm : fwd(m_rt, m_rtd));
        chk("ex_storeData", ex_storeData, fwd(m_rt, m_rtd));
      end
    end
  end

  task automatic bubble_model();
    {m_valid, m_rw, m_mr, m_mw, m_m2r} = '0;
    m_op = '0; m_dest = '0; m_known = 1'b0;
  endtask

  task automatic tick();
    logic hz;
    @(posedge clk);
    hz = exp_hazard();
    if (reset) begin
      bubble_model();
      m_rs = 0; m_rt = 0; m_rsd = 0; m_rtd = 0; m_imm = 0; m_alusrc = 0; m_known = 1'b1;
    end else if (flush) bubble_model();
    else if (stall) ;
    else if (hz) bubble_model();
    else begin
      m_valid = id_valid; m_rw = id_regWrite; m_mr = id_memRead;
      m_mw = id_memWrite; m_m2r = id_memToReg; m_op = id_aluOp;
      m_dest = id_regDst ? id_rd : id_rt;
      m_rs = id_rs; m_rt = id_rt; m_rsd = id_rs_data; m_rtd = id_rt_data;
      m_imm = (id_signExt && id_imm[15]) ? (32'hFFFF_0000 + id_imm) : {16'h0, id_imm};
      m_alusrc = id_aluSrc; m_known = 1'b1;
    end
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [3:0] op, input logic rw, input logic mr, input logic rdst);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
    id_aluOp = op; id_regWrite = rw; id_memRead = mr; id_memToReg = mr; id_regDst = rdst;
    id_memWrite = 1'b0; id_aluSrc = 1'b0; id_signExt = 1'b0; id_imm = 16'h0;
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0;
    set_id(0, 0, 0, 0, 0, 0, ALU_AND, 0, 0, 0);
    exmem_regWrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_regWrite = 0; memwb_rd = 0; memwb_result = 0;
    tick(); tick();
    started = 1;
    chk("rst_opCode", opCode, 4'b0000);
    chk("rst_valid", ex_valid, 1'b0);
    chk("rst_A", A, 32'd0);
    reset = 0;

    // Basic capture, one cycle later on the ALU ports
    set_id(1, 1, 2, 3, 1000, 200, ALU_ADD, 1, 0, 1);
    tick();
    chk("add_opCode", opCode, 4'b0010);
    chk("add_A", A, 32'd1000);
    chk("add_B", B, 32'd200);
    chk("add_valid", ex_valid, 1'b1);

    // Forwarding priority on rs=8
    set_id(1, 8, 2, 3, 1, 2, ALU_OR, 1, 0, 1);
    tick();
    exmem_regWrite = 1; exmem_rd = 8; exmem_result = 55;
    memwb_regWrite = 1; memwb_rd = 8; memwb_result = 77;
    #1 chk("fwd_exmem_A", A, 32'd55);
    exmem_regWrite = 0;
    #1 chk("fwd_memwb_A", A, 32'd77);
    memwb_regWrite = 0;

    // $0 must not forward
    set_id(1, 0, 2, 3, 0, 5, ALU_ADD, 1, 0, 1);
    tick();
    exmem_regWrite = 1; exmem_rd = 0; exmem_result = 99;
    #1 chk("no_fwd_r0_A", A, 32'd0);
    exmem_regWrite = 0;

    // Load-use: LW $9 in EX, ADD reading $9 in ID
    set_id(1, 3, 9, 0, 4, 6, ALU_ADD, 1, 1, 0);
    tick();
    chk("lw_dest", ex_destReg, 5'd9);
    set_id(1, 9, 4, 10, 11, 12, ALU_ADD, 1, 0, 1);
    #1 chk("hazard_on", load_use_hazard, 1'b1);
    tick();
    chk("bubble_valid", ex_valid, 1'b0);
    chk("bubble_regWrite", ex_regWrite, 1'b0);
    tick();
    chk("held_add_valid", ex_valid, 1'b1);
    chk("held_add_dest", ex_destReg, 5'd10);

    // Immediate extension
    set_id(1, 1, 2, 3, 7, 32'h1234, ALU_ADD, 1, 0, 0);
    id_aluSrc = 1; id_signExt = 1; id_imm = 16'hFFFE;
    tick();
    chk("sext_B", B, 32'hFFFF_FFFE);
    chk("sext_store", ex_storeData, 32'h1234);
    id_signExt = 0;
    tick();
    chk("zext_B", B, 32'h0000_FFFE);
    chk("zext_store", ex_storeData, 32'h1234);

    // Flush beats stall
    set_id(1, 1, 2, 3, 10, 20, ALU_SUB, 1, 0, 1);
    tick();
    stall = 1; flush = 1;
    tick();
    chk("flush_stall_valid", ex_valid, 1'b0);
    flush = 0; stall = 0;

    // Stall holds for 3 cycles while ID changes
    tick();
    set_id(1, 5, 6, 7, 30, 40, ALU_NOR, 0, 0, 1);
    stall = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("stall_opCode", opCode, ALU_SUB);
    chk("stall_A", A, 32'd10);
    stall = 0;

    // Hazard persists across stall, bubble on first free edge
    set_id(1, 2, 5, 0, 1, 2, ALU_ADD, 1, 1, 0);
    tick();
    set_id(1, 5, 1, 12, 3, 4, ALU_SLT, 1, 0, 1);
    stall = 1;
    tick(); tick();
    chk("stall_hazard", load_use_hazard, 1'b1);
    chk("stall_hazard_valid", ex_valid, 1'b1);
    stall = 0;
    tick();
    chk("post_stall_bubble", ex_valid, 1'b0);
    tick();
    chk("post_stall_slt", opCode, ALU_SLT);

    // Reset during stall clears everything
    stall = 1; reset = 1;
    tick();
    chk("rst_stall_valid", ex_valid, 1'b0);
    chk("rst_stall_opCode", opCode, 4'b0000);
    chk("rst_stall_dest", ex_destReg, 5'd0);
    reset = 0; stall = 0;
    tick(); tick();

    started = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
